// File: rtl/order_matcher_if.sv
// Order-entry, cancel, halt and trade-report signals of the order matcher.
// The slave modport is the matcher's view; master is the order source's view.
interface order_matcher_if #(
    parameter int DEPTH = 4,
    parameter int PW    = 8,
    parameter int QW    = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          buy_valid;
    logic [PW-1:0] buy_price;
    logic [QW-1:0] buy_qty;
    logic          buy_ready;
    logic          sell_valid;
    logic [PW-1:0] sell_price;
    logic [QW-1:0] sell_qty;
    logic          sell_ready;
    logic          buy_cancel;
    logic          sell_cancel;
    logic          halt_signal;
    logic          match_signal;
    logic          enable_count;
    logic [PW-1:0] trade_price;
    logic [QW-1:0] trade_qty;
    logic [LW-1:0] buy_level;
    logic [LW-1:0] sell_level;
    logic          reject;

    modport master (
        output buy_valid, buy_price, buy_qty, sell_valid, sell_price, sell_qty,
               buy_cancel, sell_cancel, halt_signal,
        input  buy_ready, sell_ready, match_signal, enable_count,
               trade_price, trade_qty, buy_level, sell_level, reject
    );

    modport slave (
        input  buy_valid, buy_price, buy_qty, sell_valid, sell_price, sell_qty,
               buy_cancel, sell_cancel, halt_signal,
        output buy_ready, sell_ready, match_signal, enable_count,
               trade_price, trade_qty, buy_level, sell_level, reject
    );
endinterface

// File: rtl/order_matcher.sv
// Order matcher: buffers buy/sell orders in per-side FIFOs and crosses the
// two heads at most once per cycle, reporting each trade as a one-cycle pulse.
// A sticky halt from the trade counter freezes all trading until reset.
module order_matcher #(
    parameter int DEPTH = 4,
    parameter int PW    = 8,
    parameter int QW    = 4
) (
    input logic            slow_clk,
    input logic            reset_n,
    order_matcher_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {RUN, HALTED} state_t;
    state_t state_q, state_d;

    logic [PW-1:0] buy_price_mem  [DEPTH];
    logic [QW-1:0] buy_qty_mem    [DEPTH];
    logic [PW-1:0] sell_price_mem [DEPTH];
    logic [QW-1:0] sell_qty_mem   [DEPTH];

    logic [AW-1:0] buy_rd_q, buy_wr_q, sell_rd_q, sell_wr_q;
    logic [LW-1:0] buy_level_q, sell_level_q;
    logic          match_q, reject_q;
    logic [PW-1:0] trade_price_q;
    logic [QW-1:0] trade_qty_q;

    logic          run, cancel_any, match;
    logic          buy_empty, sell_empty, buy_full, sell_full;
    logic          buy_accept, sell_accept, buy_push, sell_push;
    logic          buy_pop, sell_pop, buy_upd, sell_upd;
    logic [PW-1:0] buy_head_price, sell_head_price;
    logic [QW-1:0] buy_head_qty, sell_head_qty;
    logic [QW-1:0] fill_qty, buy_rem, sell_rem;

    // State register: RUN out of reset
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Next state: halt is sticky, only reset leaves HALTED
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && bus.halt_signal) state_d = HALTED;
    end

    // Head crossing, cancel and accept decisions for this cycle
    always_comb begin
        run             = (state_q == RUN);
        buy_empty       = (buy_level_q == '0);
        sell_empty      = (sell_level_q == '0);
        buy_full        = (buy_level_q == LW'(DEPTH));
        sell_full       = (sell_level_q == LW'(DEPTH));
        buy_head_price  = buy_price_mem[buy_rd_q];
        buy_head_qty    = buy_qty_mem[buy_rd_q];
        sell_head_price = sell_price_mem[sell_rd_q];
        sell_head_qty   = sell_qty_mem[sell_rd_q];
        cancel_any      = bus.buy_cancel || bus.sell_cancel;
        match           = run && !buy_empty && !sell_empty && !cancel_any &&
                          (buy_head_price >= sell_head_price);
        fill_qty        = (buy_head_qty < sell_head_qty) ? buy_head_qty : sell_head_qty;
        buy_rem         = buy_head_qty - fill_qty;
        sell_rem        = sell_head_qty - fill_qty;
        buy_pop         = run && !buy_empty && (bus.buy_cancel || (match && buy_rem == '0));
        sell_pop        = run && !sell_empty && (bus.sell_cancel || (match && sell_rem == '0));
        buy_upd         = match && (buy_rem != '0);
        sell_upd        = match && (sell_rem != '0);
        buy_accept      = bus.buy_valid && run && !buy_full;
        sell_accept     = bus.sell_valid && run && !sell_full;
        buy_push        = buy_accept && (bus.buy_qty != '0);
        sell_push       = sell_accept && (bus.sell_qty != '0);
    end

    // Order storage: push at tail, partial fills rewrite the head quantity.
    // A full FIFO never pushes and an empty one never fills, so the two
    // writes cannot land on the same entry.
    always_ff @(posedge slow_clk) begin
        if (buy_push) begin
            buy_price_mem[buy_wr_q] <= bus.buy_price;
            buy_qty_mem[buy_wr_q]   <= bus.buy_qty;
        end
        if (buy_upd) buy_qty_mem[buy_rd_q] <= buy_rem;
        if (sell_push) begin
            sell_price_mem[sell_wr_q] <= bus.sell_price;
            sell_qty_mem[sell_wr_q]   <= bus.sell_qty;
        end
        if (sell_upd) sell_qty_mem[sell_rd_q] <= sell_rem;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            buy_rd_q     <= '0;
            buy_wr_q     <= '0;
            buy_level_q  <= '0;
            sell_rd_q    <= '0;
            sell_wr_q    <= '0;
            sell_level_q <= '0;
        end else begin
            if (buy_push)  buy_wr_q  <= buy_wr_q + AW'(1);
            if (buy_pop)   buy_rd_q  <= buy_rd_q + AW'(1);
            if (sell_push) sell_wr_q <= sell_wr_q + AW'(1);
            if (sell_pop)  sell_rd_q <= sell_rd_q + AW'(1);
            if (buy_push && !buy_pop)      buy_level_q <= buy_level_q + LW'(1);
            else if (!buy_push && buy_pop) buy_level_q <= buy_level_q - LW'(1);
            if (sell_push && !sell_pop)      sell_level_q <= sell_level_q + LW'(1);
            else if (!sell_push && sell_pop) sell_level_q <= sell_level_q - LW'(1);
        end
    end

    // Registered trade report and zero-quantity reject pulse
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q       <= 1'b0;
            reject_q      <= 1'b0;
            trade_price_q <= '0;
            trade_qty_q   <= '0;
        end else begin
            match_q  <= match;
            reject_q <= (buy_accept && bus.buy_qty == '0) ||
                        (sell_accept && bus.sell_qty == '0);
            if (match) begin
                trade_price_q <= sell_head_price;
                trade_qty_q   <= fill_qty;
            end
        end
    end

    assign bus.buy_ready    = run && !buy_full;
    assign bus.sell_ready   = run && !sell_full;
    assign bus.match_signal = match_q;
    assign bus.enable_count = match_q;
    assign bus.trade_price  = trade_price_q;
    assign bus.trade_qty    = trade_qty_q;
    assign bus.buy_level    = buy_level_q;
    assign bus.sell_level   = sell_level_q;
    assign bus.reject       = reject_q;
endmodule

// File: tb/tb_order_matcher.sv
// Testbench for order_matcher: directed scenarios plus randomized traffic,
// checked against a queue-based order-book model with a pulse scoreboard.
module tb_order_matcher;
    localparam int DEPTH = 4;
    localparam int PW    = 8;
    localparam int QW    = 4;

    logic slow_clk = 1'b0;
    logic reset_n  = 1'b1;

    order_matcher_if #(.DEPTH(DEPTH), .PW(PW), .QW(QW)) bus ();

    order_matcher #(.DEPTH(DEPTH), .PW(PW), .QW(QW)) dut (
        .slow_clk (slow_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 slow_clk = ~slow_clk;

    typedef struct {int price; int qty;} order_t;
    typedef struct {int cyc; int price; int qty;} trade_t;

    order_t buy_m[$];
    order_t sell_m[$];
    trade_t trade_q[$];
    int     reject_q[$];
    bit     halted_m   = 1'b0;
    int     last_price = 0;
    int     last_qty   = 0;
    int     cyc        = 0;
    int     n_checks   = 0;
    int     n_fail     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an order book stepped once per clock edge
    always @(posedge slow_clk or negedge reset_n) begin
        bit   m, bacc, sacc;
        int   t;
        order_t o;
        if (!reset_n) begin
            buy_m.delete();
            sell_m.delete();
            trade_q.delete();
            reject_q.delete();
            halted_m   = 1'b0;
            last_price = 0;
            last_qty   = 0;
        end else begin
            cyc++;
            if (!halted_m) begin
                bacc = bus.buy_valid && (buy_m.size() < DEPTH);
                sacc = bus.sell_valid && (sell_m.size() < DEPTH);
                m = 1'b0;
                if (!bus.buy_cancel && !bus.sell_cancel && buy_m.size() > 0 && sell_m.size() > 0)
                    m = (buy_m[0].price >= sell_m[0].price);
                if (m) begin
                    t = (buy_m[0].qty < sell_m[0].qty) ? buy_m[0].qty : sell_m[0].qty;
                    last_price = sell_m[0].price;
                    last_qty   = t;
                    trade_q.push_back('{cyc: cyc, price: last_price, qty: t});
                    buy_m[0].qty  -= t;
                    sell_m[0].qty -= t;
                    if (buy_m[0].qty == 0)  void'(buy_m.pop_front());
                    if (sell_m[0].qty == 0) void'(sell_m.pop_front());
                end else begin
                    if (bus.buy_cancel && buy_m.size() > 0)   void'(buy_m.pop_front());
                    if (bus.sell_cancel && sell_m.size() > 0) void'(sell_m.pop_front());
                end
                if (bacc && bus.buy_qty != 0) begin
                    o.price = int'(bus.buy_price);
                    o.qty   = int'(bus.buy_qty);
                    buy_m.push_back(o);
                end
                if (sacc && bus.sell_qty != 0) begin
                    o.price = int'(bus.sell_price);
                    o.qty   = int'(bus.sell_qty);
                    sell_m.push_back(o);
                end
                if ((bacc && bus.buy_qty == 0) || (sacc && bus.sell_qty == 0))
                    reject_q.push_back(cyc);
                if (bus.halt_signal) halted_m = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard when a pulse is due and checks held state
    always @(negedge slow_clk) begin
        bit     exp_pulse, exp_rej;
        trade_t tr;
        exp_pulse = 1'b0;
        exp_rej   = 1'b0;
        if (trade_q.size() > 0) if (trade_q[0].cyc == cyc) exp_pulse = 1'b1;
        if (reject_q.size() > 0) if (reject_q[0] == cyc) exp_rej = 1'b1;
        chk("match_signal", 32'(bus.match_signal), 32'(exp_pulse));
        chk("enable_count", 32'(bus.enable_count), 32'(exp_pulse));
        chk("reject", 32'(bus.reject), 32'(exp_rej));
        if (exp_pulse) begin
            tr = trade_q.pop_front();
            chk("pulse_trade_price", 32'(bus.trade_price), 32'(tr.price));
            chk("pulse_trade_qty", 32'(bus.trade_qty), 32'(tr.qty));
        end
        if (exp_rej) void'(reject_q.pop_front());
        chk("trade_price_held", 32'(bus.trade_price), 32'(last_price));
        chk("trade_qty_held", 32'(bus.trade_qty), 32'(last_qty));
        chk("buy_level", 32'(bus.buy_level), 32'(buy_m.size()));
        chk("sell_level", 32'(bus.sell_level), 32'(sell_m.size()));
        chk("buy_ready", 32'(bus.buy_ready), 32'(!halted_m && buy_m.size() < DEPTH));
        chk("sell_ready", 32'(bus.sell_ready), 32'(!halted_m && sell_m.size() < DEPTH));
    end

    task automatic drive(input bit bv, input int bp, input int bq,
                         input bit sv, input int sp, input int sq,
                         input bit bc, input bit sc, input bit h);
        @(negedge slow_clk);
        #1;
        bus.buy_valid   = bv;
        bus.buy_price   = PW'(bp);
        bus.buy_qty     = QW'(bq);
        bus.sell_valid  = sv;
        bus.sell_price  = PW'(sp);
        bus.sell_qty    = QW'(sq);
        bus.buy_cancel  = bc;
        bus.sell_cancel = sc;
        bus.halt_signal = h;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_seq();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge slow_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int halt_cycles;
        bus.buy_valid = 0; bus.buy_price = '0; bus.buy_qty = '0;
        bus.sell_valid = 0; bus.sell_price = '0; bus.sell_qty = '0;
        bus.buy_cancel = 0; bus.sell_cancel = 0; bus.halt_signal = 0;
        #1 reset_n = 1'b0;
        @(negedge slow_clk);
        @(negedge slow_clk);
        #1 reset_n = 1'b1;

        // Full cross at sell price
        drive(1, 10, 3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 9, 3, 0, 0, 0);
        idle(3);
        // Partial fill leaves buy remainder, then cancel it
        drive(1, 10, 5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 10, 2, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Non-crossing heads, sell cancel
        drive(1, 5, 1, 1, 8, 1, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Fill buy FIFO, overflow attempt, cancel frees a slot
        for (int i = 0; i < DEPTH; i++) drive(1, 1 + i, 2, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 7, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        reset_seq();
        // Halt coincident with the first trade edge
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 9, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 9, 1, 0, 0, 1);
        drive(1, 12, 1, 1, 3, 1, 1, 1, 0);
        idle(4);
        reset_seq();
        // Zero-quantity reject, then reset with orders queued
        drive(1, 20, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        drive(1, 3, 2, 1, 7, 2, 0, 0, 0);
        drive(1, 4, 2, 1, 0, 0, 0, 0, 0);
        idle(1);
        reset_seq();
        idle(2);

        // Randomized traffic
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 249) == 0));
            if (halted_m) halt_cycles++;
            if (halt_cycles > 6) begin
                reset_seq();
                halt_cycles = 0;
            end
        end
        idle(5);
        chk("trades_drained", 32'(trade_q.size()), 32'd0);
        chk("rejects_drained", 32'(reject_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
